// File: rtl/serial_adder_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract unit: the controller
//   state encoding, the operation codes and a small helper for the signed
//   overflow flag.
// ----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    // Controller states. The encoding matches the ALU-wide definitions.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation select values on the op input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement overflow: carry into the MSB differs from carry out.
    function automatic logic signed_ovf(input logic i_c_msb_in, input logic i_c_out);
        return i_c_msb_in ^ i_c_out;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// ----------------------------------------------------------------------------
// fullAdder
//   Gate-level one-bit full adder; the single arithmetic cell that the
//   serial controller reuses once per bit.
// Ports
//   i_a, i_b  : operand bits
//   i_cin     : carry in
//   o_sum     : sum bit
//   o_cout    : carry out
// ----------------------------------------------------------------------------
module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_sum  = w_axb ^ i_cin;
    assign o_cout = (i_a & i_b) | (w_axb & i_cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial add/subtract unit. One full-adder cell is shared across WIDTH
//   clock cycles, LSB first, under a start/busy/done handshake. Returns
//   {carry, sum} and a signed-overflow flag.
// Parameters
//   WIDTH     : operand width, 2..16
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   start     : request, only sampled while idle
//   op        : 0 = a+b, 1 = a-b, sampled with start
//   a, b      : operands, sampled with start
//   busy      : high while running and during the done cycle
//   done      : one-cycle pulse, s/overflow valid from this cycle on
//   s         : registered {carry_out, sum}, holds until the next done
//   overflow  : signed overflow of the last operation, holds with s
// ----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   s,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_s;
    logic               r_overflow;

    logic               w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;

    // Single shared bit slice: always works on the current LSBs.
    fullAdder u_fa (
        .i_a    (r_op_a[0]),
        .i_b    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Accept and last-bit qualifiers shared by FSM and datapath.
    always_comb begin
        w_accept = 1'b0;
        w_last   = 1'b0;
        if (r_state == ST_IDLE) begin
            w_accept = start;
        end else begin
            w_accept = 1'b0;
        end
        if ((r_state == ST_RUN) && (r_cnt == CNT_LAST)) begin
            w_last = 1'b1;
        end else begin
            w_last = 1'b0;
        end
    end

    // Controller next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand/result shift registers, carry flop, bit counter and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_s        <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            r_op_a  <= a;
            r_op_b  <= (op == OP_SUB) ? ~b : b;
            r_carry <= (op == OP_ADD) ? 1'b0 : 1'b1;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
            r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // r_carry here is the carry into the MSB; the result is
                // published in one step so partial shifts never reach s.
                r_s        <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
                r_overflow <= signed_ovf(r_carry, w_cout);
            end else begin
                r_s        <= r_s;
                r_overflow <= r_overflow;
            end
        end else begin
            r_op_a <= r_op_a;
            r_op_b <= r_op_b;
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign s        = r_s;
    assign overflow = r_overflow;

endmodule
